// File: rtl/cpu6502_subroutine_sequencer.sv
// JSR abs / RTS sequencer: pushes or pulls the return address on the page-1 stack
// over five bus cycles, then strobes the new PC and SP into their registers.
module cpu6502_subroutine_sequencer #(
  parameter logic [7:0] STACK_PAGE = 8'h01
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        opJsr,
  input  logic        opRts,
  input  logic [15:0] currentPC,
  input  logic [7:0]  currentSP,
  input  logic [7:0]  dataIn,
  output logic [15:0] busAddress,
  output logic [7:0]  busDataOut,
  output logic        busWrite,
  output logic [15:0] newPC,
  output logic        pcLoad,
  output logic [7:0]  newSP,
  output logic        spLoad,
  output logic        busy
);

  typedef enum logic [3:0] {
    IDLE,
    J_FETCH_LO,
    J_DUMMY,
    J_PUSH_HI,
    J_PUSH_LO,
    J_FETCH_HI,
    R_DUMMY_PC,
    R_DUMMY_SP,
    R_PULL_LO,
    R_PULL_HI,
    R_DUMMY_RET,
    DONE
  } seqState_t;

  seqState_t state, nextState;

  logic [15:0] pcReg;
  logic [7:0]  spReg;
  logic        isJsr;
  logic [7:0]  lo, hi;

  logic [7:0]  nextLo, nextHi;
  logic [15:0] effPC, retAddr;
  logic [7:0]  effSP, spMinus1, spMinus2, spPlus1, spPlus2;

  logic [15:0] nextBusAddress;
  logic [7:0]  nextBusDataOut;
  logic        nextBusWrite;
  logic [15:0] nextNewPC;
  logic [7:0]  nextNewSP;
  logic        nextLoad;
  logic        nextBusy;

  always_comb begin
    nextState = state;
    case (state)
      IDLE:        if (start && (opJsr || opRts)) nextState = opJsr ? J_FETCH_LO : R_DUMMY_PC;
      J_FETCH_LO:  nextState = J_DUMMY;
      J_DUMMY:     nextState = J_PUSH_HI;
      J_PUSH_HI:   nextState = J_PUSH_LO;
      J_PUSH_LO:   nextState = J_FETCH_HI;
      J_FETCH_HI:  nextState = DONE;
      R_DUMMY_PC:  nextState = R_DUMMY_SP;
      R_DUMMY_SP:  nextState = R_PULL_LO;
      R_PULL_LO:   nextState = R_PULL_HI;
      R_PULL_HI:   nextState = R_DUMMY_RET;
      R_DUMMY_RET: nextState = DONE;
      DONE:        nextState = IDLE;
      default:     nextState = IDLE;
    endcase
  end

  // Outputs are registered, so they are computed for the state being entered;
  // from IDLE the operands come straight from the inputs since the latches are not yet loaded.
  always_comb begin
    effPC    = (state == IDLE) ? currentPC : pcReg;
    effSP    = (state == IDLE) ? currentSP : spReg;
    retAddr  = effPC + 16'd1;
    spMinus1 = effSP - 8'd1;
    spMinus2 = effSP - 8'd2;
    spPlus1  = effSP + 8'd1;
    spPlus2  = effSP + 8'd2;

    nextLo = lo;
    nextHi = hi;
    case (state)
      J_FETCH_LO, R_PULL_LO: nextLo = dataIn;
      J_FETCH_HI, R_PULL_HI: nextHi = dataIn;
      default: ;
    endcase

    nextBusAddress = '0;
    nextBusDataOut = '0;
    nextBusWrite   = 1'b0;
    nextNewPC      = newPC;
    nextNewSP      = newSP;
    nextLoad       = 1'b0;
    nextBusy       = (nextState != IDLE);

    case (nextState)
      J_FETCH_LO, R_DUMMY_PC: nextBusAddress = effPC;
      J_DUMMY, R_DUMMY_SP:    nextBusAddress = {STACK_PAGE, effSP};
      J_PUSH_HI: begin
        nextBusAddress = {STACK_PAGE, effSP};
        nextBusWrite   = 1'b1;
        nextBusDataOut = retAddr[15:8];
      end
      J_PUSH_LO: begin
        nextBusAddress = {STACK_PAGE, spMinus1};
        nextBusWrite   = 1'b1;
        nextBusDataOut = retAddr[7:0];
      end
      J_FETCH_HI:  nextBusAddress = retAddr;
      R_PULL_LO:   nextBusAddress = {STACK_PAGE, spPlus1};
      R_PULL_HI:   nextBusAddress = {STACK_PAGE, spPlus2};
      R_DUMMY_RET: nextBusAddress = {nextHi, nextLo};
      DONE: begin
        nextLoad = 1'b1;
        if (isJsr) begin
          nextNewPC = {nextHi, nextLo};
          nextNewSP = spMinus2;
        end else begin
          nextNewPC = {nextHi, nextLo} + 16'd1;
          nextNewSP = spPlus2;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      pcReg      <= '0;
      spReg      <= '0;
      isJsr      <= 1'b0;
      lo         <= '0;
      hi         <= '0;
      busAddress <= '0;
      busDataOut <= '0;
      busWrite   <= 1'b0;
      newPC      <= '0;
      pcLoad     <= 1'b0;
      newSP      <= '0;
      spLoad     <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state <= nextState;
      if (state == IDLE && nextState != IDLE) begin
        pcReg <= currentPC;
        spReg <= currentSP;
        isJsr <= opJsr;
      end
      lo         <= nextLo;
      hi         <= nextHi;
      busAddress <= nextBusAddress;
      busDataOut <= nextBusDataOut;
      busWrite   <= nextBusWrite;
      newPC      <= nextNewPC;
      pcLoad     <= nextLoad;
      newSP      <= nextNewSP;
      spLoad     <= nextLoad;
      busy       <= nextBusy;
    end
  end

endmodule

// File: tb/tb_cpu6502_subroutine_sequencer.sv
// Bench for the JSR/RTS sequencer: bus memory plus a transaction-level model of
// the expected bus trace and PC/SP results.
module tb_cpu6502_subroutine_sequencer;

  logic        clk;
  logic        reset;
  logic        start;
  logic        opJsr;
  logic        opRts;
  logic [15:0] currentPC;
  logic [7:0]  currentSP;
  logic [7:0]  dataIn;
  logic [15:0] busAddress;
  logic [7:0]  busDataOut;
  logic        busWrite;
  logic [15:0] newPC;
  logic        pcLoad;
  logic [7:0]  newSP;
  logic        spLoad;
  logic        busy;

  logic [7:0] mem    [0:65535];
  logic [7:0] refMem [0:65535];

  int passCnt  = 0;
  int totalCnt = 0;

  cpu6502_subroutine_sequencer #(.STACK_PAGE(8'h01)) dut (
    .clk(clk), .reset(reset), .start(start), .opJsr(opJsr), .opRts(opRts),
    .currentPC(currentPC), .currentSP(currentSP), .dataIn(dataIn),
    .busAddress(busAddress), .busDataOut(busDataOut), .busWrite(busWrite),
    .newPC(newPC), .pcLoad(pcLoad), .newSP(newSP), .spLoad(spLoad), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign dataIn = mem[busAddress];

  always @(posedge clk) begin
    if (busWrite) mem[busAddress] <= busDataOut;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    totalCnt++;
    assert (obs === exp) passCnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic poke(input logic [15:0] a, input logic [7:0] d);
    mem[a]    = d;
    refMem[a] = d;
  endtask

  task automatic checkIdleOutputs(input string tag);
    check({tag, ".busAddress"}, {16'h0, busAddress}, 32'h0);
    check({tag, ".busDataOut"}, {24'h0, busDataOut}, 32'h0);
    check({tag, ".busWrite"},   {31'h0, busWrite},   32'h0);
    check({tag, ".newPC"},      {16'h0, newPC},      32'h0);
    check({tag, ".pcLoad"},     {31'h0, pcLoad},     32'h0);
    check({tag, ".newSP"},      {24'h0, newSP},      32'h0);
    check({tag, ".spLoad"},     {31'h0, spLoad},     32'h0);
    check({tag, ".busy"},       {31'h0, busy},       32'h0);
  endtask

  // Caller is at a negedge with the sequencer idle; returns at the negedge of the idle cycle after DONE.
  task automatic runOp(input string tag, input bit jsr, input bit both,
                       input logic [15:0] pc, input logic [7:0] sp);
    logic [15:0] ea [5];
    logic        ew [5];
    logic [7:0]  ed [5];
    logic [15:0] r, expPC;
    logic [7:0]  expSP, s1, s2, sm1, lo, hi;
    if (jsr) begin
      r   = pc + 16'd1;
      sm1 = sp - 8'd1;
      lo  = refMem[pc];
      ea[0] = pc;             ew[0] = 0; ed[0] = 8'h00;
      ea[1] = {8'h01, sp};    ew[1] = 0; ed[1] = 8'h00;
      ea[2] = {8'h01, sp};    ew[2] = 1; ed[2] = r[15:8];
      ea[3] = {8'h01, sm1};   ew[3] = 1; ed[3] = r[7:0];
      refMem[{8'h01, sp}]  = r[15:8];
      refMem[{8'h01, sm1}] = r[7:0];
      hi    = refMem[r];
      ea[4] = r;              ew[4] = 0; ed[4] = 8'h00;
      expPC = {hi, lo};
      expSP = sp - 8'd2;
    end else begin
      s1 = sp + 8'd1;
      s2 = sp + 8'd2;
      lo = refMem[{8'h01, s1}];
      hi = refMem[{8'h01, s2}];
      ea[0] = pc;             ew[0] = 0; ed[0] = 8'h00;
      ea[1] = {8'h01, sp};    ew[1] = 0; ed[1] = 8'h00;
      ea[2] = {8'h01, s1};    ew[2] = 0; ed[2] = 8'h00;
      ea[3] = {8'h01, s2};    ew[3] = 0; ed[3] = 8'h00;
      ea[4] = {hi, lo};       ew[4] = 0; ed[4] = 8'h00;
      expPC = {hi, lo} + 16'd1;
      expSP = s2;
    end

    currentPC = pc;
    currentSP = sp;
    opJsr     = jsr | both;
    opRts     = !jsr | both;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      check($sformatf("%s.addr%0d", tag, i),  {16'h0, busAddress}, {16'h0, ea[i]});
      check($sformatf("%s.write%0d", tag, i), {31'h0, busWrite},   {31'h0, ew[i]});
      check($sformatf("%s.data%0d", tag, i),  {24'h0, busDataOut}, {24'h0, ed[i]});
      check($sformatf("%s.busy%0d", tag, i),  {31'h0, busy},       32'h1);
      check($sformatf("%s.noLoad%0d", tag, i), {31'h0, pcLoad},    32'h0);
      // Disturb every captured input mid-sequence; none of it may matter.
      if (i == 1) begin
        start     = 1'b1;
        opJsr     = $urandom_range(1, 0);
        opRts     = !opJsr;
        currentPC = 16'($urandom);
        currentSP = 8'($urandom);
      end
      if (i == 2) start = 1'b0;
    end
    @(negedge clk);
    check({tag, ".pcLoad"},   {31'h0, pcLoad},   32'h1);
    check({tag, ".spLoad"},   {31'h0, spLoad},   32'h1);
    check({tag, ".newPC"},    {16'h0, newPC},    {16'h0, expPC});
    check({tag, ".newSP"},    {24'h0, newSP},    {24'h0, expSP});
    check({tag, ".doneBusy"}, {31'h0, busy},     32'h1);
    check({tag, ".doneWr"},   {31'h0, busWrite}, 32'h0);
    @(negedge clk);
    check({tag, ".idleBusy"},   {31'h0, busy},   32'h0);
    check({tag, ".idlePcLoad"}, {31'h0, pcLoad}, 32'h0);
    check({tag, ".idleSpLoad"}, {31'h0, spLoad}, 32'h0);
    if (jsr) begin
      check({tag, ".memHi"}, {24'h0, mem[{8'h01, sp}]}, {24'h0, refMem[{8'h01, sp}]});
      check({tag, ".memLo"}, {24'h0, mem[{8'h01, sm1}]}, {24'h0, refMem[{8'h01, sm1}]});
    end
  endtask

  initial begin
    logic [15:0] r;
    logic [7:0]  sm1;
    logic [7:0]  keepLo;
    reset = 1'b1; start = 1'b0; opJsr = 1'b0; opRts = 1'b0;
    currentPC = '0; currentSP = '0;
    for (int a = 0; a < 65536; a++) poke(16'(a), 8'($urandom));

    repeat (3) @(negedge clk);
    checkIdleOutputs("reset");
    reset = 1'b0;
    @(negedge clk);

    // JSR basic
    poke(16'h1234, 8'h00);
    poke(16'h1235, 8'h80);
    runOp("jsrBasic", 1, 0, 16'h1234, 8'hFD);
    check("jsrBasic.mem01FD", {24'h0, mem[16'h01FD]}, 32'h12);
    check("jsrBasic.mem01FC", {24'h0, mem[16'h01FC]}, 32'h35);

    // RTS basic, back-to-back with the JSR above
    runOp("rtsBasic", 0, 0, 16'h8001, 8'hFB);
    check("rtsBasic.newPC", {16'h0, newPC}, 32'h1236);

    // Stack wrap JSR
    runOp("jsrWrap", 1, 0, 16'h4000, 8'h00);
    check("jsrWrap.mem0100", {24'h0, mem[16'h0100]}, 32'h40);
    check("jsrWrap.mem01FF", {24'h0, mem[16'h01FF]}, 32'h01);

    // Stack wrap RTS with PC wrap
    poke(16'h01FF, 8'hFF);
    poke(16'h0100, 8'hFF);
    runOp("rtsWrap", 0, 0, 16'h2222, 8'hFE);
    check("rtsWrap.newPC", {16'h0, newPC}, 32'h0000);

    // Both ops high executes JSR
    runOp("bothOps", 1, 1, 16'hABCD, 8'h80);

    // Start with neither op stays idle
    opJsr = 1'b0; opRts = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("noOp.busy", {31'h0, busy}, 32'h0);
    check("noOp.addr", {16'h0, busAddress}, 32'h0);
    @(negedge clk);
    check("noOp.busy2", {31'h0, busy}, 32'h0);

    // Reset during J_PUSH_HI
    currentPC = 16'h5678; currentSP = 8'h40; opJsr = 1'b1; opRts = 1'b0; start = 1'b1;
    r = 16'h5679; sm1 = 8'h3F;
    keepLo = refMem[{8'h01, sm1}];
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst.pushHiWrite", {31'h0, busWrite}, 32'h1);
    reset = 1'b1;
    refMem[{8'h01, 8'h40}] = r[15:8];
    @(negedge clk);
    reset = 1'b0;
    checkIdleOutputs("rst");
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check($sformatf("rst.noLoad%0d", i),  {31'h0, pcLoad},   32'h0);
      check($sformatf("rst.noWrite%0d", i), {31'h0, busWrite}, 32'h0);
    end
    check("rst.hiWritten", {24'h0, mem[16'h0140]}, {24'h0, r[15:8]});
    check("rst.loUntouched", {24'h0, mem[{8'h01, sm1}]}, {24'h0, keepLo});

    // Randomized back-to-back traffic
    for (int n = 0; n < 60; n++) begin
      runOp($sformatf("rnd%0d", n), 1'($urandom_range(1, 0)), 1'b0,
            16'($urandom), 8'($urandom));
    end

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
